// File: rtl/nes_joypad_pkg.sv
// nes_joypad_pkg: reader state encoding, button bit positions and default pad timing
package nes_joypad_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, GAP, PULSE, DONE} state_t;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
  localparam int LATCH_CYCLES_DEF = 300;
  localparam int HALF_CYCLES_DEF = 150;
  localparam int POLL_CYCLES_DEF = 416667;
  function automatic int max3(int a, int b, int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/joypad_reader_if.sv
// joypad_reader_if: pad wires plus host-side button bytes and frame handshake
interface joypad_reader_if;
  logic poll_now;
  logic pad_data_1;
  logic pad_data_2;
  logic pad_latch;
  logic pad_clk;
  logic [7:0] joycon_1;
  logic [7:0] joycon_2;
  logic joy_valid;
  logic busy;
  modport master(
    input poll_now, pad_data_1, pad_data_2,
    output pad_latch, pad_clk, joycon_1, joycon_2, joy_valid, busy
  );
  modport slave(
    output poll_now, pad_data_1, pad_data_2,
    input pad_latch, pad_clk, joycon_1, joycon_2, joy_valid, busy
  );
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer; resets to 1, the idle level of an unpressed pad line
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (!rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/joypad_reader.sv
// joypad_reader: polls two NES pads over a shared latch/clock and registers their button bytes.
// Define JOYPAD_DEBOUNCE_EN to accept a pad's byte only after two identical consecutive frames.
module joypad_reader
  import nes_joypad_pkg::*;
#(
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF,
  parameter int HALF_CYCLES = HALF_CYCLES_DEF,
  parameter int POLL_CYCLES = POLL_CYCLES_DEF
) (
  input logic clk,
  input logic rst,
  joypad_reader_if.master bus
);
  localparam int CW = $clog2(max3(LATCH_CYCLES, HALF_CYCLES, POLL_CYCLES));
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tmr;
  logic [2:0] idx;
  logic [7:0] sh_1, sh_2;
  logic s_1, s_2;
  logic expire, start;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0] prev_1, prev_2;
`endif
  sync2 u_sync_1 (.clk(clk), .rst(rst), .d(bus.pad_data_1), .q(s_1));
  sync2 u_sync_2 (.clk(clk), .rst(rst), .d(bus.pad_data_2), .q(s_2));
  // poll timer counts down: POLL_CYCLES-1 is phase 0, zero is the expiry phase
  assign expire = tmr == '0;
  assign start = (state == IDLE) && (bus.poll_now || expire);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      tmr <= CW'(POLL_CYCLES - 1);
      idx <= '0;
      sh_1 <= '0;
      sh_2 <= '0;
      bus.pad_latch <= 1'b0;
      bus.pad_clk <= 1'b0;
      bus.joycon_1 <= '0;
      bus.joycon_2 <= '0;
      bus.joy_valid <= 1'b0;
      bus.busy <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
      prev_1 <= '0;
      prev_2 <= '0;
`endif
    end else begin
      tmr <= (expire || (start && bus.poll_now)) ? CW'(POLL_CYCLES - 1) : tmr - 1'b1;
      bus.joy_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LATCH;
          cnt <= CW'(LATCH_CYCLES - 1);
          bus.pad_latch <= 1'b1;
          bus.busy <= 1'b1;
        end
        LATCH: if (cnt == '0) begin
          state <= GAP;
          cnt <= CW'(HALF_CYCLES - 1);
          idx <= '0;
          bus.pad_latch <= 1'b0;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) begin
          sh_1[idx] <= ~s_1;
          sh_2[idx] <= ~s_2;
          state <= PULSE;
          cnt <= CW'(HALF_CYCLES - 1);
          bus.pad_clk <= 1'b1;
        end else cnt <= cnt - 1'b1;
        PULSE: if (cnt == '0) begin
          bus.pad_clk <= 1'b0;
          if (idx == 3'd7) begin
            state <= DONE;
            bus.joy_valid <= 1'b1;
`ifdef JOYPAD_DEBOUNCE_EN
            if (sh_1 == prev_1) bus.joycon_1 <= sh_1;
            if (sh_2 == prev_2) bus.joycon_2 <= sh_2;
            prev_1 <= sh_1;
            prev_2 <= sh_2;
`else
            bus.joycon_1 <= sh_1;
            bus.joycon_2 <= sh_2;
`endif
          end else begin
            idx <= idx + 1'b1;
            state <= GAP;
            cnt <= CW'(HALF_CYCLES - 1);
          end
        end else cnt <= cnt - 1'b1;
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_joypad_reader.sv
// tb_joypad_reader: 4021 pad models plus a frame-position reference model compared every cycle
module tb_joypad_reader;
  import nes_joypad_pkg::*;
  localparam int L = 4, H = 3, P = 200, F = L + 16 * H + 1;
`ifdef JOYPAD_DEBOUNCE_EN
  localparam logic [7:0] A1 = 8'h00, A2 = 8'h00, D1 = 8'h00, D2 = 8'h00, D3 = 8'h01;
`else
  localparam logic [7:0] A1 = 8'h09, A2 = 8'h80, D1 = 8'hFF, D2 = 8'h01, D3 = 8'h01;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0, failures = 0;
  logic [7:0] btn_1 = '0, btn_2 = '0;
  logic [7:0] sr_1 = '0, sr_2 = '0;
  logic clk_q = 1'b0;
  joypad_reader_if bus ();
  joypad_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .POLL_CYCLES(P)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // pads: parallel load while latched, shift toward bit 0 on each rising pad_clk
  always @(negedge clk) begin
    if (bus.pad_latch) begin
      sr_1 = btn_1;
      sr_2 = btn_2;
    end else if (bus.pad_clk && !clk_q) begin
      sr_1 = sr_1 >> 1;
      sr_2 = sr_2 >> 1;
    end
    clk_q = bus.pad_clk;
    bus.pad_data_1 = ~sr_1[0];
    bus.pad_data_2 = ~sr_2[0];
  end

  // reference: k is the 1-based position within a frame, 0 when idle
  int k = 0, tmr = 0;
  logic start;
  logic [7:0] raw_1, raw_2, mj_1 = '0, mj_2 = '0, pv_1 = '0, pv_2 = '0;
  always @(posedge clk) begin
    if (!rst) begin
      k = 0; tmr = 0; mj_1 = '0; mj_2 = '0; pv_1 = '0; pv_2 = '0;
    end else begin
      start = (k == 0) && (bus.poll_now || tmr == P - 1);
      tmr = ((start && bus.poll_now) || tmr == P - 1) ? 0 : tmr + 1;
      k = start ? 1 : (k == 0 || k == F) ? 0 : k + 1;
      if (start) begin
        raw_1 = btn_1;
        raw_2 = btn_2;
      end
      if (k == F) begin
`ifdef JOYPAD_DEBOUNCE_EN
        if (raw_1 == pv_1) mj_1 = raw_1;
        if (raw_2 == pv_2) mj_2 = raw_2;
        pv_1 = raw_1;
        pv_2 = raw_2;
`else
        mj_1 = raw_1;
        mj_2 = raw_2;
`endif
      end
    end
  end

  logic [19:0] ev, av;
  always @(negedge clk) begin
    ev = {k >= 1 && k <= L, k > L && k < F && ((k - L - 1) / H) % 2 == 1, k != 0, k == F, mj_1, mj_2};
    av = {bus.pad_latch, bus.pad_clk, bus.busy, bus.joy_valid, bus.joycon_1, bus.joycon_2};
    chk("cycle", 32'(av), 32'(ev));
  end

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b);
    btn_1 = a;
    btn_2 = b;
    bus.poll_now = 1'b1;
    @(negedge clk);
    bus.poll_now = 1'b0;
    repeat (54) @(negedge clk);
  endtask

  int nv, nb, nc, nl, vat, auto_at, nb2, vat2;
  logic pc;
  logic [7:0] j1, j2, k1, k2;
  initial begin
    bus.poll_now = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(bus.pad_latch), 32'd0);
    chk("rst_padclk", 32'(bus.pad_clk), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.joy_valid), 32'd0);
    chk("rst_joy", 32'({bus.joycon_1, bus.joycon_2}), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    btn_1 = 8'((1 << BTN_A) | (1 << BTN_START));
    btn_2 = 8'(1 << BTN_RIGHT);
    bus.poll_now = 1'b1;
    nv = 0; nb = 0; nc = 0; nl = 0; vat = 0; auto_at = 0; nb2 = 0; vat2 = 0;
    pc = 1'b0; j1 = 'x; j2 = 'x; k1 = 'x; k2 = 'x;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      bus.poll_now = (i == 20);
      if (i == 60) begin
        btn_1 = '0;
        btn_2 = 8'h00;
      end
      if (i <= 100) begin
        nv += int'(bus.joy_valid);
        nb += int'(bus.busy);
        nl += int'(bus.pad_latch);
        if (bus.pad_clk && !pc) nc++;
        pc = bus.pad_clk;
        if (bus.joy_valid) vat = i;
        if (i == 53) begin
          j1 = bus.joycon_1;
          j2 = bus.joycon_2;
        end
      end else begin
        if (bus.busy && auto_at == 0) auto_at = i;
        nb2 += int'(bus.busy);
        if (bus.joy_valid) begin
          vat2 = i;
          k1 = bus.joycon_1;
          k2 = bus.joycon_2;
        end
      end
    end
    chk("a_joy1", 32'(j1), 32'(A1));
    chk("a_joy2", 32'(j2), 32'(A2));
    chk("a_valid_count", 32'(nv), 32'd1);
    chk("a_valid_cycle", 32'(vat), 32'd53);
    chk("a_busy_len", 32'(nb), 32'd53);
    chk("a_latch_len", 32'(nl), 32'd4);
    chk("a_pulses", 32'(nc), 32'd8);
    chk("b_auto_start", 32'(auto_at), 32'd201);
    chk("b_busy_len", 32'(nb2), 32'd53);
    chk("b_valid_cycle", 32'(vat2), 32'd253);
    chk("b_joy", 32'({k1, k2}), 32'd0);
    run_frame(8'h09, 8'h80);
    run_frame(8'h09, 8'h80);
    chk("c_prior_joy1", 32'(bus.joycon_1), 32'h09);
    chk("c_prior_joy2", 32'(bus.joycon_2), 32'h80);
    btn_1 = 8'h09;
    bus.poll_now = 1'b1;
    @(negedge clk);
    bus.poll_now = 1'b0;
    repeat (29) @(negedge clk);
    chk("c_busy_mid", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("c_latch", 32'(bus.pad_latch), 32'd0);
    chk("c_padclk", 32'(bus.pad_clk), 32'd0);
    chk("c_joy1", 32'(bus.joycon_1), 32'd0);
    chk("c_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(8'hFF, 8'h00);
    chk("d_frame1", 32'(bus.joycon_1), 32'(D1));
    run_frame(8'h01, 8'h00);
    chk("d_frame2", 32'(bus.joycon_1), 32'(D2));
    run_frame(8'h01, 8'h00);
    chk("d_frame3", 32'(bus.joycon_1), 32'(D3));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
